enc_stream_merger: RTL

- Generalised output selector for the RS encoder.
- Merges the message stream and per-codeword parity blocks into a continuous stream of SYM-symbol output beats.
- Tracks codeword position internally and supports runtime shortening (cfg_mes_len).
- Has valid/ready flow control on both the parity input and the output. Sits between the message buffer / parity generator and the encoder output port.

---
 rtl/enc_stream_merger_pkg.sv | 27 ++
 rtl/enc_merge_mux.sv | 67 ++++++
 rtl/enc_stream_merger.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/enc_stream_merger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc_stream_merger_pkg
//  Description : Shared types and defaults for the RS encoder output merger.
//                Holds the beat-phase encoding, the symbol width and the
//                default parity length.
//  Revision    : 1.0 - initial release
// ============================================================================
package enc_stream_merger_pkg;

  localparam int EGF_DIM     = 8;   // bits per Galois-field symbol
  localparam int RSC_PAR_LEN = 16;  // default parity symbols per codeword

  // What an output beat is made of:
  //   SEL_MES : message only
  //   SEL_MTP : message tail followed by parity head
  //   SEL_PAR : parity only
  //   SEL_PTM : parity tail followed by the next codeword's message head
  typedef enum logic [1:0] {
    SEL_MES = 2'd0,
    SEL_MTP = 2'd1,
    SEL_PAR = 2'd2,
    SEL_PTM = 2'd3
  } sel_phase_t;

endpackage
`default_nettype wire

// File: rtl/enc_merge_mux.sv
`default_nettype none
// ============================================================================
//  Module      : enc_merge_mux
//  Description : Combinational lane mux that builds one output beat from the
//                message head window and the parity register.
//  Ports       : phase    - beat composition
//                cnt      - m (MTP: message symbols) or p (PTM: parity symbols)
//                mes_data - message window, lane SYM-1 oldest
//                par_data - parity block, index PAR_LEN-1 transmitted first
//                par_off  - parity symbols already transmitted from par_data
//                beat     - assembled beat, lane SYM-1 earliest
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_merge_mux
  import enc_stream_merger_pkg::*;
#(
  parameter  int SYM     = 4,
  parameter  int DIM     = EGF_DIM,
  parameter  int PAR_LEN = RSC_PAR_LEN,
  localparam int CW      = $clog2(SYM + 1),
  localparam int OW      = $clog2(PAR_LEN + 1)
) (
  input  sel_phase_t             phase,
  input  logic [CW-1:0]          cnt,
  input  logic [SYM*DIM-1:0]     mes_data,
  input  logic [PAR_LEN*DIM-1:0] par_data,
  input  logic [OW-1:0]          par_off,
  output logic [SYM*DIM-1:0]     beat
);

  // k-th oldest message symbol of the window
  function automatic logic [DIM-1:0] mes_sym(input logic [SYM*DIM-1:0] v, input int k);
    if (k < 0 || k >= SYM) return '0;
    return DIM'(v >> ((SYM - 1 - k) * DIM));
  endfunction

  // parity symbol at absolute index idx
  function automatic logic [DIM-1:0] par_sym(input logic [PAR_LEN*DIM-1:0] v, input int idx);
    if (idx < 0 || idx >= PAR_LEN) return '0;
    return DIM'(v >> (idx * DIM));
  endfunction

  int             w_n;
  int             w_off;
  logic [DIM-1:0] w_sym;

  // pos counts beat positions in transmission order (0 = lane SYM-1)
  always_comb begin
    w_n   = int'(cnt);
    w_off = int'(par_off);
    w_sym = '0;
    beat  = '0;
    for (int pos = 0; pos < SYM; pos++) begin
      case (phase)
        SEL_MES: w_sym = mes_sym(mes_data, pos);
        SEL_MTP: w_sym = (pos < w_n) ? mes_sym(mes_data, pos)
                                     : par_sym(par_data, PAR_LEN - 1 - w_off - (pos - w_n));
        SEL_PAR: w_sym = par_sym(par_data, PAR_LEN - 1 - w_off - pos);
        default: w_sym = (pos < w_n) ? par_sym(par_data, PAR_LEN - 1 - w_off - pos)
                                     : mes_sym(mes_data, pos - w_n);
      endcase
      beat[(SYM-1-pos)*DIM +: DIM] = w_sym;
    end
  end

endmodule
`default_nettype wire

// File: rtl/enc_stream_merger.sv
`default_nettype none
// ============================================================================
//  Module      : enc_stream_merger
//  Description : Merges the message stream and per-codeword parity blocks
//                into a continuous stream of SYM-symbol beats, tracking the
//                codeword position with runtime shortening.
//  Ports       : cfg_mes_len            - message length, sampled at codeword start
//                mes_data/mes_avail     - message head window and its fill level
//                mes_pop                - message symbols consumed (combinational)
//                par_in_data/valid/ready- parity block handshake
//                out_data/valid/ready   - output beat handshake
//                out_last               - beat holds the final parity symbol
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_stream_merger
  import enc_stream_merger_pkg::*;
#(
  parameter  int SYM         = 4,
  parameter  int DIM         = EGF_DIM,
  parameter  int PAR_LEN     = RSC_PAR_LEN,
  parameter  int MES_LEN_MAX = 239,
  localparam int MW          = $clog2(MES_LEN_MAX + 1),
  localparam int AW          = $clog2(SYM + 1),
  localparam int PW          = $clog2(PAR_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [MW-1:0]          cfg_mes_len,
  input  logic [SYM*DIM-1:0]     mes_data,
  input  logic [AW-1:0]          mes_avail,
  output logic [AW-1:0]          mes_pop,
  input  logic [PAR_LEN*DIM-1:0] par_in_data,
  input  logic                   par_in_valid,
  output logic                   par_in_ready,
  output logic [SYM*DIM-1:0]     out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam logic [MW-1:0] SYM_M = MW'(SYM);
  localparam logic [PW-1:0] SYM_P = PW'(SYM);
  localparam logic [AW-1:0] SYM_A = AW'(SYM);
  localparam logic [PW-1:0] PAR_P = PW'(PAR_LEN);

  logic [MW-1:0]          r_mes_left;
  logic [PW-1:0]          r_par_left;
  logic                   r_boundary;
  logic [PAR_LEN*DIM-1:0] r_par;
  logic                   r_par_full;

  logic [MW-1:0]          w_mes_eff;
  logic [PW-1:0]          w_par_eff;
  logic [PW-1:0]          w_par_off;
  sel_phase_t             w_phase;
  logic [AW-1:0]          w_cnt;
  logic [AW-1:0]          w_need_mes;
  logic                   w_need_par;
  logic [MW-1:0]          w_mes_nxt;
  logic [PW-1:0]          w_par_nxt;
  logic                   w_bnd_nxt;
  logic                   w_last;
  logic                   w_par_done;
  logic                   w_ready;
  logic                   w_load;
  logic [SYM*DIM-1:0]     w_beat;

  // At a boundary the counters behave as if already reloaded from cfg.
  assign w_mes_eff = r_boundary ? cfg_mes_len : r_mes_left;
  assign w_par_eff = r_boundary ? PAR_P : r_par_left;
  assign w_par_off = PAR_P - w_par_eff;

  always_comb begin
    w_phase    = SEL_PAR;
    w_cnt      = '0;
    w_need_mes = '0;
    w_need_par = 1'b1;
    w_mes_nxt  = w_mes_eff;
    w_par_nxt  = w_par_eff;
    w_bnd_nxt  = 1'b0;
    w_last     = 1'b0;
    w_par_done = 1'b0;
    if (w_mes_eff >= SYM_M) begin
      w_phase    = SEL_MES;
      w_need_mes = SYM_A;
      w_need_par = 1'b0;
      w_mes_nxt  = w_mes_eff - SYM_M;
    end else if (w_mes_eff != '0) begin
      w_phase    = SEL_MTP;
      w_cnt      = AW'(w_mes_eff);
      w_need_mes = AW'(w_mes_eff);
      w_mes_nxt  = '0;
      w_par_nxt  = w_par_eff - (SYM_P - PW'(w_mes_eff));
    end else if (w_par_eff >= SYM_P) begin
      w_phase    = SEL_PAR;
      w_par_nxt  = w_par_eff - SYM_P;
      if (w_par_eff == SYM_P) begin
        w_bnd_nxt  = 1'b1;
        w_last     = 1'b1;
        w_par_done = 1'b1;
      end
    end else begin
      // Parity tail shares the beat with the next codeword's first symbols,
      // so that codeword starts here rather than through the boundary flag.
      w_phase    = SEL_PTM;
      w_cnt      = AW'(w_par_eff);
      w_need_mes = SYM_A - AW'(w_par_eff);
      w_mes_nxt  = cfg_mes_len - MW'(SYM_A - AW'(w_par_eff));
      w_par_nxt  = PAR_P;
      w_last     = 1'b1;
      w_par_done = 1'b1;
    end
  end

  assign w_ready      = (w_need_mes <= mes_avail) && (!w_need_par || r_par_full);
  assign w_load       = w_ready && (!out_valid || out_ready);
  assign mes_pop      = w_load ? w_need_mes : '0;
  assign par_in_ready = !r_par_full;

  enc_merge_mux #(
    .SYM     (SYM),
    .DIM     (DIM),
    .PAR_LEN (PAR_LEN)
  ) u_mux (
    .phase    (w_phase),
    .cnt      (w_cnt),
    .mes_data (mes_data),
    .par_data (r_par),
    .par_off  (w_par_off),
    .beat     (w_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      r_mes_left <= '0;
      r_par_left <= '0;
      r_boundary <= 1'b1;
      r_par      <= '0;
      r_par_full <= 1'b0;
    end else begin
      if (w_load) begin
        out_data   <= w_beat;
        out_last   <= w_last;
        out_valid  <= 1'b1;
        r_mes_left <= w_mes_nxt;
        r_par_left <= w_par_nxt;
        r_boundary <= w_bnd_nxt;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
      // Fill and drain are exclusive: fill needs empty, drain needs full.
      if (par_in_valid && !r_par_full) begin
        r_par      <= par_in_data;
        r_par_full <= 1'b1;
      end else if (w_load && w_par_done) begin
        r_par_full <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
